// File: rtl/cpu_debug_ctrl_if.sv
// Command channel from the PDU to cpu_debug_ctrl.
// Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready; op/idx/data are held while valid.
interface cpu_debug_ctrl_if #(
  parameter int XLEN = 32,
  parameter int IW   = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [IW-1:0]   cmd_idx;
  logic [XLEN-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_idx, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_idx, input cmd_data, output cmd_ready);
endinterface

// File: rtl/cpu_debug_ctrl.sv
// Run-control (run/step/halt, PC breakpoints) and committed-PC trace for a single-cycle RV32 CPU.
// Optional instret counter is built when DBG_INSTRET_EN is defined; otherwise instret is tied to 0.
module cpu_debug_ctrl #(
  parameter int XLEN        = 32,
  parameter int NUM_BP      = 4,
  parameter int TRACE_DEPTH = 16,
  localparam int IW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int TW = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  cpu_debug_ctrl_if.slave   cmd,
  input  logic [XLEN-1:0]   current_pc,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [NUM_BP-1:0] bp_hit,
  input  logic [TW-1:0]     trace_rd_idx,
  output logic [XLEN-1:0]   trace_rd_data,
  output logic [TW:0]       trace_count,
  output logic [XLEN-1:0]   instret,
  output logic [1:0]        dbg_state
);
  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  localparam logic [2:0] OP_RUN  = 3'd0;
  localparam logic [2:0] OP_STEP = 3'd1;
  localparam logic [2:0] OP_HALT = 3'd2;
  localparam logic [2:0] OP_SET  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_CLRT = 3'd5;

  localparam logic [1:0] C_RESET = 2'd0;
  localparam logic [1:0] C_CMD   = 2'd1;
  localparam logic [1:0] C_STEP  = 2'd2;
  localparam logic [1:0] C_BP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              skip_q, skip_d;
  logic [1:0]        cause_q, cause_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic [NUM_BP-1:0] bp_en_q;
  logic [XLEN-1:0]   bp_addr_q [NUM_BP];
  logic [XLEN-1:0]   trace_q [TRACE_DEPTH];
  logic [TW-1:0]     wptr_q;
  logic [TW:0]       count_q;
  logic [NUM_BP-1:0] match_vec;
  logic              match;
  logic              cmd_fire;
  logic              idx_ok;
  logic              clr_trace;
  logic [TW-1:0]     rd_ptr;

  assign cmd.cmd_ready = (state_q != S_STEP);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_ok        = 32'(cmd.cmd_idx) < 32'(NUM_BP);
  assign clr_trace     = cmd_fire && (cmd.cmd_op == OP_CLRT);

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      match_vec[i] = bp_en_q[i] && (bp_addr_q[i] == current_pc);
    end
  end
  assign match = |match_vec;

  // skip_q lets the first RUN cycle commit the instruction sitting on a breakpoint.
  assign cpu_en = rst && ((state_q == S_STEP) ||
                          ((state_q == S_RUN) && (skip_q || !match)));

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    cause_d  = cause_q;
    bp_hit_d = bp_hit_q;
    case (state_q)
      S_HALT: begin
        if (cmd_fire && cmd.cmd_op == OP_RUN) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (cmd_fire && cmd.cmd_op == OP_STEP) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
        cause_d = C_STEP;
      end
      S_RUN: begin
        skip_d = 1'b0;
        if (match && !skip_q) begin
          state_d  = S_HALT;
          cause_d  = C_BP;
          bp_hit_d = match_vec;
        end else if (cmd_fire && cmd.cmd_op == OP_HALT) begin
          state_d = S_HALT;
          cause_d = C_CMD;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_HALT;
      skip_q   <= 1'b0;
      cause_q  <= C_RESET;
      bp_hit_q <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      cause_q  <= cause_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bp_en_q <= '0;
    end else if (cmd_fire && idx_ok) begin
      if (cmd.cmd_op == OP_SET) begin
        bp_en_q[cmd.cmd_idx]   <= 1'b1;
        bp_addr_q[cmd.cmd_idx] <= cmd.cmd_data;
      end else if (cmd.cmd_op == OP_CLR) begin
        bp_en_q[cmd.cmd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else if (clr_trace) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else if (cpu_en) begin
      wptr_q <= wptr_q + 1'b1;
      if (count_q != (TW+1)'(TRACE_DEPTH)) count_q <= count_q + 1'b1;
    end
  end

  // Trace storage needs no reset: entries beyond count_q are don't-care.
  always_ff @(posedge clk) begin
    if (cpu_en && !clr_trace) trace_q[wptr_q] <= current_pc;
  end

  assign rd_ptr        = wptr_q - TW'(1) - trace_rd_idx;
  assign trace_rd_data = trace_q[rd_ptr];
  assign trace_count   = count_q;

`ifdef DBG_INSTRET_EN
  logic [XLEN-1:0] instret_q;
  always_ff @(posedge clk) begin
    if (!rst || clr_trace) instret_q <= '0;
    else if (cpu_en)       instret_q <= instret_q + 1'b1;
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif

  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign bp_hit     = bp_hit_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: directed run-control scenarios, then randomized commands against a reference model.
module tb_cpu_debug_ctrl;
  localparam int XLEN  = 32;
  localparam int NBP   = 4;
  localparam int DEPTH = 16;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_debug_ctrl_if #(.XLEN(XLEN), .IW(2)) cmd_if ();

  logic [XLEN-1:0] current_pc;
  logic            cpu_en;
  logic            halted;
  logic [1:0]      halt_cause;
  logic [NBP-1:0]  bp_hit;
  logic [3:0]      trace_rd_idx;
  logic [XLEN-1:0] trace_rd_data;
  logic [4:0]      trace_count;
  logic [XLEN-1:0] instret;
  logic [1:0]      dbg_state;

  cpu_debug_ctrl #(.XLEN(XLEN), .NUM_BP(NBP), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .current_pc(current_pc), .cpu_en(cpu_en), .halted(halted),
    .halt_cause(halt_cause), .bp_hit(bp_hit),
    .trace_rd_idx(trace_rd_idx), .trace_rd_data(trace_rd_data),
    .trace_count(trace_count), .instret(instret), .dbg_state(dbg_state)
  );

  // reference model
  int              m_mode;
  bit              m_first;
  logic [1:0]      m_cause;
  logic [NBP-1:0]  m_bphit;
  logic [XLEN-1:0] m_bpa [NBP];
  bit              m_bpe [NBP];
  logic [XLEN-1:0] exp_q [$];   // committed PCs, newest first
  logic [XLEN-1:0] m_inst;
  logic [XLEN-1:0] pc_m;
  bit              rand_pc;
  int              dut_commits;
  int              n_tests;
  int              n_fail;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_instret();
`ifdef DBG_INSTRET_EN
    return m_inst;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_mode  = M_HALT;
    m_first = 0;
    m_cause = 2'd0;
    m_bphit = '0;
    for (int i = 0; i < NBP; i++) m_bpe[i] = 0;
    exp_q.delete();
    m_inst = '0;
  endtask

  // driver: one clock cycle with the given reset level and command
  task automatic cycle(input bit r, input bit v, input logic [2:0] op, input logic [1:0] idx,
                       input logic [XLEN-1:0] data);
    logic [NBP-1:0] mv;
    bit match, exp_en, fire;
    int sel;
    @(negedge clk);
    rst               = r;
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_idx    = idx;
    cmd_if.cmd_data   = data;
    current_pc        = pc_m;
    sel               = $urandom_range(0, DEPTH-1);
    trace_rd_idx      = sel[3:0];
    #1;
    mv = '0;
    for (int i = 0; i < NBP; i++) if (m_bpe[i] && m_bpa[i] == pc_m) mv[i] = 1'b1;
    match  = |mv;
    exp_en = r && (m_mode == M_STEP || (m_mode == M_RUN && (m_first || !match)));
    fire   = v && (m_mode != M_STEP);
    check_eq("cpu_en", cpu_en, exp_en);
    check_eq("halted", halted, m_mode == M_HALT);
    check_eq("cmd_ready", cmd_if.cmd_ready, m_mode != M_STEP);
    check_eq("halt_cause", halt_cause, m_cause);
    check_eq("bp_hit", bp_hit, m_bphit);
    check_eq("trace_count", trace_count, exp_q.size());
    check_eq("instret", instret, exp_instret());
    if (sel < exp_q.size()) check_eq("trace_rd_data", trace_rd_data, exp_q[sel]);
    if (cpu_en === 1'b1) dut_commits++;

    if (!r) begin
      model_reset();
    end else begin
      if (fire && op == 3'd5) begin
        exp_q.delete();
        m_inst = '0;
      end else if (exp_en) begin
        exp_q.push_front(pc_m);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        m_inst++;
      end
      if (fire && op == 3'd3) begin m_bpa[idx] = data; m_bpe[idx] = 1; end
      if (fire && op == 3'd4) m_bpe[idx] = 0;
      case (m_mode)
        M_HALT: begin
          if (fire && op == 3'd0) begin m_mode = M_RUN; m_first = 1; end
          else if (fire && op == 3'd1) m_mode = M_STEP;
        end
        M_STEP: begin m_mode = M_HALT; m_cause = 2'd2; end
        default: begin
          if (match && !m_first) begin m_mode = M_HALT; m_cause = 2'd3; m_bphit = mv; end
          else if (fire && op == 3'd2) begin m_mode = M_HALT; m_cause = 2'd1; end
          m_first = 0;
        end
      endcase
    end
    if (exp_en) begin
      if (rand_pc && $urandom_range(0, 4) == 0) pc_m = XLEN'($urandom_range(0, 15) * 4);
      else if (rand_pc) pc_m = (pc_m + 4) & 32'h3C;
      else pc_m = pc_m + 4;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 3'd7, 2'd0, '0);
  endtask

  // only used while halted, so the extra cycle has no effect
  task automatic settle(input logic [3:0] sel);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    trace_rd_idx     = sel;
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; dut_commits = 0; rand_pc = 0; pc_m = '0;
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_idx = '0; cmd_if.cmd_data = '0;
    current_pc = '0; trace_rd_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    idle(3);
    settle(0);
    check_eq("rst_halted", halted, 1);
    check_eq("rst_cause", halt_cause, 0);
    check_eq("rst_cpu_en", cpu_en, 0);
    check_eq("rst_count", trace_count, 0);

    // single step at pc 0
    pc_m = 0; dut_commits = 0;
    cycle(1, 1, 3'd1, 2'd0, '0);
    idle(2);
    settle(0);
    check_eq("step_commits", dut_commits, 1);
    check_eq("step_cause", halt_cause, 2);
    check_eq("step_trace0", trace_rd_data, 32'h0);
    check_eq("step_count", trace_count, 1);

    // breakpoint at 0x10 in slot 2
    pc_m = 0; dut_commits = 0;
    cycle(1, 1, 3'd3, 2'd2, 32'h10);
    cycle(1, 1, 3'd0, 2'd0, '0);
    idle(8);
    settle(0);
    check_eq("bp_commits", dut_commits, 4);
    check_eq("bp_cause", halt_cause, 3);
    check_eq("bp_hit_slot", bp_hit, 4'b0100);
    check_eq("bp_trace0", trace_rd_data, 32'hC);

    // resume past breakpoint, then halt by command
    dut_commits = 0;
    cycle(1, 1, 3'd0, 2'd0, '0);
    idle(3);
    cycle(1, 1, 3'd2, 2'd0, '0);
    idle(1);
    settle(0);
    check_eq("resume_commits", dut_commits, 4);
    check_eq("halt_cmd_cause", halt_cause, 1);
    check_eq("resume_trace0", trace_rd_data, 32'h1C);
    settle(3);
    check_eq("resume_trace3", trace_rd_data, 32'h10);

    // 20 commits wrap the trace
    cycle(1, 1, 3'd5, 2'd0, '0);
    cycle(1, 1, 3'd4, 2'd2, '0);
    pc_m = 32'h100; dut_commits = 0;
    cycle(1, 1, 3'd0, 2'd0, '0);
    idle(19);
    cycle(1, 1, 3'd2, 2'd0, '0);
    idle(1);
    settle(0);
    check_eq("wrap_commits", dut_commits, 20);
    check_eq("wrap_count", trace_count, 16);
    check_eq("wrap_trace0", trace_rd_data, 32'h14C);
    settle(15);
    check_eq("wrap_trace15", trace_rd_data, 32'h110);

    // instret over 7 steps, then CLR_TRACE
    cycle(1, 1, 3'd5, 2'd0, '0);
    for (int k = 0; k < 7; k++) begin
      cycle(1, 1, 3'd1, 2'd0, '0);
      idle(1);
    end
    settle(0);
`ifdef DBG_INSTRET_EN
    check_eq("instret_7", instret, 7);
`else
    check_eq("instret_off", instret, 0);
`endif
    check_eq("instret_count", trace_count, 7);
    cycle(1, 1, 3'd5, 2'd0, '0);
    settle(0);
    check_eq("instret_clr", instret, 0);

    // randomized phase
    rand_pc = 1; pc_m = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, v;
      logic [2:0] op;
      r  = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 2) == 0);
      op = 3'($urandom_range(0, 7));
      cycle(r, v, op, 2'($urandom_range(0, 3)), XLEN'($urandom_range(0, 15) * 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
